// File: rtl/pi_cmd_receiver_pkg.sv
// Shared types and constants for the Raspberry Pi command receiver.
// The pin word layout is defined here so the filter and the control logic agree on it.
package pi_cmd_receiver_pkg;

  localparam int DEFAULT_STABLE_CYCLES = 1200;   // 100 us at 12 MHz
  localparam int DEFAULT_ACK_CYCLES    = 12000;  // 1 ms at 12 MHz

  localparam logic [1:0] AMOUNT_SMALL   = 2'b00;
  localparam logic [1:0] AMOUNT_MED     = 2'b01;
  localparam logic [1:0] AMOUNT_LARGE   = 2'b10;
  localparam logic [1:0] AMOUNT_INVALID = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } cmd_fsm_e;

  typedef struct packed {
    logic [2:0] state;
    logic [1:0] amount;
    logic       candy;
  } pi_word_t;

  localparam int PI_WORD_W = $bits(pi_word_t);

  function automatic logic amount_is_valid(input logic [1:0] amount);
    return amount != AMOUNT_INVALID;
  endfunction

endpackage

// File: rtl/pi_cmd_receiver_sync_filter.sv
// Two-flop synchroniser followed by a stability filter: the output only takes a
// value after STABLE_CYCLES consecutive identical synchronised samples.
module sync_filter
  import pi_cmd_receiver_pkg::*;
#(
  parameter int WIDTH         = PI_WORD_W,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_filt
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_filt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cand  <= '0;
      r_filt  <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
        // With a single-sample filter the load edge is also the accept edge.
        if (CNT_MAX == '0) begin
          r_filt <= r_sync2;
        end
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= w_cnt_inc;
        if (w_cnt_inc == CNT_MAX) begin
          r_filt <= r_cand;
        end
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/pi_cmd_receiver.sv
// Receives test-state/amount/candy commands from the Raspberry Pi, acknowledges
// accepted words on sig_rcvd, and raises dispense requests to the dispense controller.
module pi_cmd_receiver
  import pi_cmd_receiver_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int ACK_CYCLES    = DEFAULT_ACK_CYCLES
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] pi_state_i,
  input  logic [1:0] pi_amount_i,
  input  logic       pi_candy_i,
  input  logic       disp_ack,
  output logic [2:0] state_o,
  output logic       state_new,
  output logic [1:0] amount_o,
  output logic       disp_req,
  output logic [1:0] disp_amount,
  output logic       sig_rcvd,
  output logic       amount_err,
  output logic       overrun
);

  localparam int ACK_W = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_CYCLES - 1);

  pi_word_t w_raw;
  pi_word_t w_filt;
  logic     w_word_changed;
  logic     w_candy_edge;

  cmd_fsm_e         r_fsm;
  logic [ACK_W-1:0] r_ack_cnt;
  logic [2:0]       r_state;
  logic [1:0]       r_amount;
  logic             r_state_new;
  logic             r_sig_rcvd;
  logic             r_candy_prev;
  logic             r_disp_req;
  logic [1:0]       r_disp_amount;
  logic             r_amount_err;
  logic             r_overrun;

  assign w_raw = '{state: pi_state_i, amount: pi_amount_i, candy: pi_candy_i};

  sync_filter #(
    .WIDTH         (PI_WORD_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_sync_filter (
    .clk    (clk),
    .rstn   (rstn),
    .i_raw  (w_raw),
    .o_filt (w_filt)
  );

  assign w_word_changed = {w_filt.state, w_filt.amount} != {r_state, r_amount};
  assign w_candy_edge   = w_filt.candy & ~r_candy_prev;

  // Changes seen during ACK are not latched; IDLE re-compares on its first cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fsm       <= ST_IDLE;
      r_ack_cnt   <= '0;
      r_state     <= '0;
      r_amount    <= '0;
      r_state_new <= 1'b0;
      r_sig_rcvd  <= 1'b0;
    end else begin
      r_state_new <= 1'b0;
      case (r_fsm)
        ST_IDLE: begin
          if (w_word_changed) begin
            r_state     <= w_filt.state;
            r_amount    <= w_filt.amount;
            r_state_new <= 1'b1;
            r_sig_rcvd  <= 1'b1;
            r_ack_cnt   <= '0;
            r_fsm       <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (r_ack_cnt == ACK_LAST) begin
            r_sig_rcvd <= 1'b0;
            r_fsm      <= ST_IDLE;
          end else begin
            r_ack_cnt <= r_ack_cnt + 1'b1;
          end
        end
        default: begin
          r_sig_rcvd <= 1'b0;
          r_fsm      <= ST_IDLE;
        end
      endcase
    end
  end

  // A pending request outranks an invalid amount: such an edge reports overrun only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_candy_prev  <= 1'b0;
      r_disp_req    <= 1'b0;
      r_disp_amount <= '0;
      r_amount_err  <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_candy_prev <= w_filt.candy;
      r_amount_err <= 1'b0;
      r_overrun    <= 1'b0;
      if (r_disp_req) begin
        if (w_candy_edge) begin
          r_overrun <= 1'b1;
        end
        if (disp_ack) begin
          r_disp_req <= 1'b0;
        end
      end else if (w_candy_edge) begin
        if (amount_is_valid(w_filt.amount)) begin
          r_disp_req    <= 1'b1;
          r_disp_amount <= w_filt.amount;
        end else begin
          r_amount_err <= 1'b1;
        end
      end
    end
  end

  assign state_o     = r_state;
  assign amount_o    = r_amount;
  assign state_new   = r_state_new;
  assign sig_rcvd    = r_sig_rcvd;
  assign disp_req    = r_disp_req;
  assign disp_amount = r_disp_amount;
  assign amount_err  = r_amount_err;
  assign overrun     = r_overrun;

endmodule
